// File: rtl/asmd_pkg.sv
// asmd_pkg: shared state encoding for the ASMD counter control path
package asmd_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        BAD  = 2'b10,
        DONE = 2'b11
    } state_t;
endpackage

// File: rtl/asmd_counter_dp.sv
// asmd_counter_dp: counter A, tracked flag E, completion flag F and run-length counter
module asmd_counter_dp
    import asmd_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int E_BIT = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clrAF,
    input  logic             incrA,
    input  logic             ldE,
    input  logic             setF,
    output logic [WIDTH-1:0] A,
    output logic             E,
    output logic             F,
    output logic [CNT_W-1:0] cycles
);
    logic [WIDTH-1:0] r_a;
    logic             r_e;
    logic             r_f;
    logic [CNT_W-1:0] r_cycles;
    // datapath registers; E samples the pre-increment A, cycles saturates at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_e      <= 1'b0;
            r_f      <= 1'b0;
            r_cycles <= '0;
        end else begin
            if (clrAF) begin
                r_a      <= '0;
                r_f      <= 1'b0;
                r_cycles <= '0;
            end else if (incrA) begin
                r_a      <= r_a + 1'b1;
                r_cycles <= (&r_cycles) ? r_cycles : r_cycles + 1'b1;
            end
            if (ldE) r_e <= r_a[E_BIT];
            if (setF) r_f <= 1'b1;
        end
    end
    assign A      = r_a;
    assign E      = r_e;
    assign F      = r_f;
    assign cycles = r_cycles;
endmodule

// File: rtl/asmd_counter_system.sv
// asmd_counter_system: ASMD control FSM with strobe decode driving the counter datapath
module asmd_counter_system
    import asmd_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] STOP_MASK = WIDTH'(4'b1100),
    parameter int               E_BIT     = 2,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] A,
    output logic             E,
    output logic             F,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycles
);
    state_t r_state;
    state_t w_next;
    logic   r_busy;
    logic   r_done;
    logic   w_clr;
    logic   w_inc;
    logic   w_set;
    logic   w_match;
    assign w_clr   = (r_state == IDLE) && start && !abort;
    assign w_inc   = (r_state == RUN) && !abort;
    assign w_set   = (r_state == DONE);
    assign w_match = (A & STOP_MASK) == STOP_MASK;
    // next state; DONE and the illegal encoding both fall back to IDLE
    always_comb begin
        w_next = w_clr ? RUN : w_inc ? (w_match ? DONE : RUN) : IDLE;
    end
    // state register with Moore outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
        end
    end
    assign busy = r_busy;
    assign done = r_done;
    asmd_counter_dp #(
        .WIDTH(WIDTH),
        .E_BIT(E_BIT),
        .CNT_W(CNT_W)
    ) u_dp (
        .clk   (clk),
        .rst   (rst),
        .clrAF (w_clr),
        .incrA (w_inc),
        .ldE   (w_inc),
        .setF  (w_set),
        .A     (A),
        .E     (E),
        .F     (F),
        .cycles(cycles)
    );
endmodule

// File: doc/asmd_counter_system.md
# asmd_counter_system

Parametrised next-generation ASMD control/datapath pair: on `start` it clears a WIDTH-bit counter `A` and flag `F`, then increments `A` every cycle while tracking bit `E_BIT` of `A` into flag `E`. When `A` matches a configurable stop pattern, it sets `F` and returns to idle. It adds a busy/done handshake, an abort input, a run-length counter and a fully defined reset state. It is the reusable form of the textbook ASMD counter example.

## Interface

Parameters:
- `WIDTH`, 4, width of counter `A` (≥2)
- `STOP_MASK`, 4'b1100 (WIDTH bits), run terminates when `(A & STOP_MASK) == STOP_MASK`
- `E_BIT`, 2, index of `A` bit copied into `E` during a run (0..WIDTH-1)
- `CNT_W`, 8, width of the `cycles` run-length counter

Ports:
- `clk` in 1: single clock, all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a run; sampled only in IDLE.
- `abort` in 1: terminate a run early.
- `A` out WIDTH: counter value.
- `E` out 1: tracked bit flag.
- `F` out 1: completion flag (sticky until next `start`).
- `busy` out 1: high in RUN or DONE.
- `done` out 1: one-cycle pulse while in DONE.
- `cycles` out CNT_W: number of RUN cycles in the current/last run.

## Operation

- States (shared package): IDLE=2'b00, RUN=2'b01, DONE=2'b11. 2'b10 is illegal and returns to IDLE next cycle with no datapath action.
- IDLE:
  - `start & ~abort` → RUN; same edge: `A<=0`, `F<=0`, `cycles<=0`. `E` holds.
  - Otherwise stay in IDLE; all registers hold.
- RUN, every cycle:
  - `A<=A+1`, mod 2^WIDTH.
  - `E<=A[E_BIT]`, using the pre-increment `A`.
  - `cycles<=cycles+1`, saturating at all-ones.
  - If `abort`: → IDLE. No increment or E update that cycle; `F` stays 0.
  - Else if `(A & STOP_MASK)==STOP_MASK` (pre-increment `A`): → DONE. The increment and E update still happen on that edge.
  - Else stay in RUN.
- DONE: `F<=1`. → IDLE unconditionally. `abort` and `start` are ignored.
- Outputs:
  - Moore: `busy = (state!=IDLE)`, `done = (state==DONE)`.
  - `A`, `E`, `F` and `cycles` are registered outputs.
- `STOP_MASK==0`: matches on the first RUN cycle, so RUN lasts exactly 1 cycle.
- `A` passes through every value, so the stop pattern is always reached within 2^WIDTH RUN cycles.

## Timing

- `rst` (synchronous) → next edge: state=IDLE, `A`=0, `E`=0, `F`=0, `cycles`=0, hence `busy`=0 and `done`=0.
- `rst` has priority over every other input in every state, including mid-run.
- Latency from `start` sampled at edge k:
  - `busy`=1 from cycle k+1.
  - RUN occupies N cycles, where N = 1 + (smallest value v ≥ 0 with `(v & STOP_MASK)==STOP_MASK`).
  - DONE occupies cycle k+1+N.
  - `F`=1 and `busy`=0 from cycle k+2+N.
- `start` held high through DONE starts no new run until IDLE samples it. With `start` held continuously, runs repeat with one IDLE cycle between them.
- `abort` in RUN: IDLE on the next cycle, and `done` is never pulsed.

## Structure

- Package `asmd_pkg`: state encoding localparams and a `state_t` 2-bit typedef.
- Sub-module `asmd_counter_dp` holds the datapath: `A`, `E`, `F`, `cycles`. It is driven by control strobes `clrAF`, `incrA`, `ldE`, `setF`.
- Top `asmd_counter_system` holds the FSM and the strobe decode, and instantiates `asmd_counter_dp`.

## Test plan

- Default params, `start` pulse after reset:
  - RUN for 13 cycles.
  - DONE pulse on the 14th cycle after start.
  - Final `A`=4'b1101, `E`=1, `F`=1, `cycles`=13, `busy` low afterwards.
- `rst` asserted on RUN cycle 5: next cycle all outputs 0, state IDLE. A following `start` runs a clean 13-cycle sequence.
- `abort` on RUN cycle 4 (`A`=3 on entry):
  - IDLE next cycle, `A`=3, `E`=0, `F`=0, `cycles`=3, no `done` pulse.
  - `start` with `abort` both high in IDLE: stays IDLE.
- `STOP_MASK`=0: `start` → exactly 1 RUN cycle, `A`=1, `F`=1, `cycles`=1.
- `WIDTH`=6, `STOP_MASK`=6'b111111, `CNT_W`=4:
  - 64 RUN cycles, `A` wraps to 0.
  - `cycles` saturates at 15.
  - `E` tracks `A[2]` each cycle.
- `start` held high for 40 cycles with defaults: back-to-back runs separated by one IDLE cycle. `F` clears on each restart; `done` pulses once per run.
